// File: rtl/lcd_img_proc_if.sv
// Host-command and image-memory bundle of the LCD image controller.
// The master drives commands and IROM read data; the slave is the controller itself.
interface lcd_img_proc_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/lcd_img_proc.sv
// LCD image controller: loads an image from IROM, edits a 2x2 window on host
// commands and streams the whole buffer to IRAM on a write command.
module lcd_img_proc #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  lcd_img_proc_if.slave     bus
);

  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_e;
  typedef enum logic [3:0] {
    C_WRITE = 4'h0, C_UP = 4'h1, C_DOWN = 4'h2, C_LEFT = 4'h3, C_RIGHT = 4'h4,
    C_MAX = 4'h5, C_MIN = 4'h6, C_AVG = 4'h7, C_ROT_CCW = 4'h8, C_ROT_CW = 4'h9,
    C_MIR_X = 4'hA, C_MIR_Y = 4'hB
  } cmd_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          irom_rd_q, irom_rd_d;
  logic [AW-1:0] irom_a_q, irom_a_d;
  logic          iram_valid_q, iram_valid_d;
  logic [AW-1:0] iram_a_q, iram_a_d;
  logic [DW-1:0] iram_d_q, iram_d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [DW-1:0] buf_mem [N];

  logic [AW-1:0] win_a [4];
  logic [DW-1:0] win_p [4];
  logic [DW-1:0] win_n [4];
  logic          win_we;
  logic [DW-1:0] win_max, win_min;
  logic [DW+1:0] win_sum;

  // Window order P0..P3 = (x-1,y-1), (x,y-1), (x-1,y), (x,y); addr = {y, x}.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    win_a[0] = {y_q - YW'(1), x_q - XW'(1)};
    win_a[1] = {y_q - YW'(1), x_q};
    win_a[2] = {y_q,          x_q - XW'(1)};
    win_a[3] = {y_q,          x_q};
    for (int i = 0; i < 4; i++) win_p[i] = buf_mem[win_a[i]];

    win_max = win_p[0];
    win_min = win_p[0];
    win_sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (win_p[i] > win_max) win_max = win_p[i];
      if (win_p[i] < win_min) win_min = win_p[i];
      win_sum = win_sum + {2'b00, win_p[i]};
    end

    win_n  = win_p;
    win_we = 1'b0;
    if (state_q == S_EXEC) begin
      win_we = 1'b1;
      case (cmd_e'(cmd_q))
        C_MAX:     for (int i = 0; i < 4; i++) win_n[i] = win_max;
        C_MIN:     for (int i = 0; i < 4; i++) win_n[i] = win_min;
        C_AVG:     for (int i = 0; i < 4; i++) win_n[i] = win_sum[DW+1:2];
        C_ROT_CCW: win_n = '{win_p[1], win_p[3], win_p[0], win_p[2]};
        C_ROT_CW:  win_n = '{win_p[2], win_p[0], win_p[3], win_p[1]};
        C_MIR_X:   win_n = '{win_p[2], win_p[3], win_p[0], win_p[1]};
        C_MIR_Y:   win_n = '{win_p[1], win_p[0], win_p[3], win_p[2]};
        default:   win_we = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cmd_d        = cmd_q;
    irom_rd_d    = irom_rd_q;
    irom_a_d     = irom_a_q;
    iram_valid_d = iram_valid_q;
    iram_a_d     = iram_a_q;
    iram_d_d     = iram_d_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        irom_a_d = irom_a_q + AW'(1);
        if (irom_a_q == AW'(N - 1)) begin
          state_d   = S_IDLE;
          irom_rd_d = 1'b0;
          irom_a_d  = '0;
          busy_d    = 1'b0;
        end
      end
      S_IDLE: begin
        if (bus.cmd_valid) begin
          busy_d = 1'b1;
          cmd_d  = bus.cmd;
          if (bus.cmd == C_WRITE) begin
            state_d      = S_WRITE;
            iram_valid_d = 1'b1;
            iram_a_d     = '0;
            iram_d_d     = buf_mem[0];
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        case (cmd_e'(cmd_q))
          C_UP:    if (y_q > YW'(1))         y_d = y_q - YW'(1);
          C_DOWN:  if (y_q < YW'(IMG_H - 1)) y_d = y_q + YW'(1);
          C_LEFT:  if (x_q > XW'(1))         x_d = x_q - XW'(1);
          C_RIGHT: if (x_q < XW'(IMG_W - 1)) x_d = x_q + XW'(1);
          default: ;
        endcase
      end
      S_WRITE: begin
        if (iram_a_q == AW'(N - 1)) begin
          state_d      = S_DONE;
          iram_valid_d = 1'b0;
          done_d       = 1'b1;
        end else begin
          iram_a_d = iram_a_q + AW'(1);
          iram_d_d = buf_mem[iram_a_q + AW'(1)];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LOAD;
      x_q          <= XW'(IMG_W / 2);
      y_q          <= YW'(IMG_H / 2);
      cmd_q        <= '0;
      irom_rd_q    <= 1'b1;
      irom_a_q     <= '0;
      iram_valid_q <= 1'b0;
      iram_a_q     <= '0;
      iram_d_q     <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cmd_q        <= cmd_d;
      irom_rd_q    <= irom_rd_d;
      irom_a_q     <= irom_a_d;
      iram_valid_q <= iram_valid_d;
      iram_a_q     <= iram_a_d;
      iram_d_q     <= iram_d_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // NOTE: the pixel buffer is deliberately not reset; every entry is rewritten by LOAD.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      buf_mem[irom_a_q] <= bus.IROM_Q;
    end else if (win_we) begin
      for (int i = 0; i < 4; i++) buf_mem[win_a[i]] <= win_n[i];
    end
  end

  assign bus.IROM_rd    = irom_rd_q;
  assign bus.IROM_A     = irom_a_q;
  assign bus.IRAM_valid = iram_valid_q;
  assign bus.IRAM_A     = iram_a_q;
  assign bus.IRAM_D     = iram_d_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
